reg_file_sb: RTL and testbench

//  Parametrised CPU register file: N read ports, 2 write ports, optional write-to-read bypass,
//  and a per-register busy scoreboard for multi-cycle/out-of-order writeback. Sits between

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_scoreboard.sv | 59 +++++
 rtl/reg_file_sb.sv | 90 +++++++++
 tb/tb_reg_file_sb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the register file and its scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_file_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int NUM_RD_MAX     = 4;
    // Write lane 1 wins over lane 0 when both target the same register.
    localparam bit LANE1_WINS     = 1'b1;

    // Low bit index of element idx in a flat bus of width-sized elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits with flush > issue > writeback-clear priority, plus population count.
// Latency: busy bits and busy_cnt update on the same clock edge as the triggering event.
// Backpressure: none; issue and writeback are accepted every cycle.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    localparam int DEPTH     = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  flush,
    input  logic                  wen0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic                  wen1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    output logic [DEPTH-1:0]      busy_q,
    output logic [ADDR_WIDTH:0]   busy_cnt
);
    logic [DEPTH-1:0]    r_busy;
    logic [ADDR_WIDTH:0] r_cnt;
    logic [DEPTH-1:0]    w_busy_d;
    logic [ADDR_WIDTH:0] w_cnt_d;

    // Next busy vector per register and its population count; register 0 never busy.
    always_comb begin
        w_busy_d = r_busy;
        w_cnt_d  = '0;
        w_busy_d[0] = 1'b0;
        for (int r = 1; r < DEPTH; r++) begin
            if (flush) begin
                w_busy_d[r] = 1'b0;
            end else if (issue_en && (issue_addr == ADDR_WIDTH'(r))) begin
                // A new producer overrides the completion of an older one.
                w_busy_d[r] = 1'b1;
            end else if ((wen0 && (waddr0 == ADDR_WIDTH'(r))) ||
                         (wen1 && (waddr1 == ADDR_WIDTH'(r)))) begin
                w_busy_d[r] = 1'b0;
            end
            w_cnt_d = w_cnt_d + (ADDR_WIDTH+1)'(w_busy_d[r]);
        end
    end

    // Busy vector and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_d;
            r_cnt  <= w_cnt_d;
        end
    end

    assign busy_q   = r_busy;
    assign busy_cnt = r_cnt;
endmodule

// File: rtl/reg_file_sb.sv
// Register file: NUM_RD combinational read ports, two write lanes, optional bypass, busy scoreboard.
// Latency: reads 0 cycles (bypass) or 1 cycle after the write edge (no bypass); writes on posedge.
// Backpressure: none; every write, issue and flush is accepted in the cycle it is presented.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wen0,
    input  logic [ADDR_WIDTH-1:0]        waddr0,
    input  logic [DATA_WIDTH-1:0]        wdata0,
    input  logic                         wen1,
    input  logic [ADDR_WIDTH-1:0]        waddr1,
    input  logic [DATA_WIDTH-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         issue_en,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    input  logic                         flush,
    output logic [ADDR_WIDTH:0]          busy_cnt
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      w_busy;
    logic                  w_wr0;
    logic                  w_wr1;

    // Writes to register 0 are discarded; reset also suppresses forwarding while held.
    assign w_wr0 = rst_n && wen0 && (waddr0 != '0);
    assign w_wr1 = rst_n && wen1 && (waddr1 != '0);

    // Storage array: lane 1 assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr0) r_mem[waddr0] <= wdata0;
            if (w_wr1) r_mem[waddr1] <= wdata1;
        end
    end

    reg_file_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .wen0       (wen0),
        .waddr0     (waddr0),
        .wen1       (wen1),
        .waddr1     (waddr1),
        .busy_q     (w_busy),
        .busy_cnt   (busy_cnt)
    );

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic                  w_hit0;
        logic                  w_hit1;
        logic                  w_sel1;

        assign w_ra   = raddr[slice_lo(g, ADDR_WIDTH) +: ADDR_WIDTH];
        assign w_hit0 = (BYPASS != 0) && w_wr0 && (waddr0 == w_ra);
        assign w_hit1 = (BYPASS != 0) && w_wr1 && (waddr1 == w_ra);
        assign w_sel1 = w_hit1 && (LANE1_WINS || !w_hit0);

        // Read mux: zero register, then forwarded write data, then stored value.
        always_comb begin
            rdata[slice_lo(g, DATA_WIDTH) +: DATA_WIDTH] = r_mem[w_ra];
            rbusy[g] = w_busy[w_ra] && !(w_hit0 || w_hit1);
            if (w_ra == '0) begin
                rdata[slice_lo(g, DATA_WIDTH) +: DATA_WIDTH] = '0;
                rbusy[g] = 1'b0;
            end else if (w_sel1) begin
                rdata[slice_lo(g, DATA_WIDTH) +: DATA_WIDTH] = wdata1;
            end else if (w_hit0) begin
                rdata[slice_lo(g, DATA_WIDTH) +: DATA_WIDTH] = wdata0;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: three instances (4-port bypass, 2-port no-bypass, 1-port bypass).
// Latency: checks combinational reads #1 after input change, registered state #1 after negedge.
// Backpressure: n/a.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen0, wen1, issue_en, flush;
    logic [4:0]  waddr0, waddr1, issue_addr;
    logic [31:0] wdata0, wdata1;
    logic [19:0] raddr;

    logic [127:0] rdata4;
    logic [3:0]   rbusy4;
    logic [5:0]   cnt4;
    logic [63:0]  rdata2;
    logic [1:0]   rbusy2;
    logic [5:0]   cnt2;
    logic [31:0]  rdata1;
    logic [0:0]   rbusy1;
    logic [5:0]   cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(4), .BYPASS(1)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata4), .rbusy(rbusy4),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .busy_cnt(cnt4)
    );

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0)) dut2n (
        .clk(clk), .rst_n(rst_n),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr[9:0]), .rdata(rdata2), .rbusy(rbusy2),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .busy_cnt(cnt2)
    );

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(1), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr[4:0]), .rdata(rdata1), .rbusy(rbusy1),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .busy_cnt(cnt1)
    );

    function automatic logic [31:0] rd4(input int p);
        return rdata4[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rd2(input int p);
        return rdata2[p*32 +: 32];
    endfunction

    task automatic set_ra(input int p, input logic [4:0] a);
        raddr[p*5 +: 5] = a;
    endtask

    task automatic idle();
        wen0 = 1'b0; wen1 = 1'b0; issue_en = 1'b0; flush = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; issue_addr = '0;
    endtask

    // Advance across one posedge, leaving the bench at the following negedge with inputs idle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle(); raddr = '0; rst_n = 1'b0;
        #1;
        total++; if (cnt4 !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt4); end
        total++; if (rd4(1) !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rd4(1)); end
        @(negedge clk); rst_n = 1'b1;
        // preload r1, r2 and mark r3 busy
        wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h55;
        wen1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h66;
        issue_en = 1'b1; issue_addr = 5'd3;
        step();
        set_ra(0, 5'd1); set_ra(1, 5'd2); set_ra(2, 5'd3);
        #1;
        total++; if (cnt4 !== 6'd1) begin bad++; $display("FAIL preload_cnt got=%0d exp=1", cnt4); end
        total++; if (rd4(0) !== 32'h55 || rd4(1) !== 32'h66) begin bad++;
            $display("FAIL preload_rdata got=%h,%h exp=55,66", rd4(0), rd4(1)); end
        total++; if (rbusy4[2] !== 1'b1) begin bad++; $display("FAIL preload_rbusy got=%b exp=1", rbusy4[2]); end
        // mid-cycle async reset
        #2 rst_n = 1'b0;
        #1;
        total++; if (rd4(0) !== 32'd0 || rd4(1) !== 32'd0) begin bad++;
            $display("FAIL midreset_rdata got=%h,%h exp=0,0", rd4(0), rd4(1)); end
        total++; if (rbusy4 !== 4'd0 || cnt4 !== 6'd0 || cnt2 !== 6'd0) begin bad++;
            $display("FAIL midreset_busy got rbusy=%b cnt=%0d/%0d exp=0", rbusy4, cnt4, cnt2); end
        @(negedge clk); rst_n = 1'b1;
        #1;
    endtask

    task automatic test_collision();
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h0BAD;
        step();
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1111;
        wen1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h2222;
        set_ra(0, 5'd5);
        #1;
        total++; if (rd4(0) !== 32'h2222) begin bad++; $display("FAIL coll_bypass got=%h exp=2222", rd4(0)); end
        total++; if (rd2(0) !== 32'h0BAD) begin bad++; $display("FAIL coll_nobypass got=%h exp=0bad", rd2(0)); end
        step();
        total++; if (rd4(0) !== 32'h2222 || rd2(0) !== 32'h2222 || rdata1 !== 32'h2222) begin bad++;
            $display("FAIL coll_stored got=%h,%h,%h exp=2222", rd4(0), rd2(0), rdata1); end
    endtask

    task automatic test_zero_reg();
        wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEAD;
        issue_en = 1'b1; issue_addr = 5'd0;
        set_ra(0, 5'd0);
        #1;
        total++; if (rd4(0) !== 32'd0 || rbusy4[0] !== 1'b0) begin bad++;
            $display("FAIL zero_same got=%h busy=%b exp=0,0", rd4(0), rbusy4[0]); end
        step();
        total++; if (rd4(0) !== 32'd0 || rd2(0) !== 32'd0 || rbusy4[0] !== 1'b0 || cnt4 !== 6'd0) begin bad++;
            $display("FAIL zero_after got=%h,%h busy=%b cnt=%0d exp=0", rd4(0), rd2(0), rbusy4[0], cnt4); end
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_addr = 5'd7;
        set_ra(1, 5'd7);
        #1;
        total++; if (rbusy4[1] !== 1'b0) begin bad++; $display("FAIL sb_issue_same got=%b exp=0", rbusy4[1]); end
        step();
        total++; if (rbusy4[1] !== 1'b1 || rbusy2[1] !== 1'b1 || cnt4 !== 6'd1) begin bad++;
            $display("FAIL sb_busy got=%b,%b cnt=%0d exp=1,1,1", rbusy4[1], rbusy2[1], cnt4); end
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hABCD;
        #1;
        total++; if (rbusy4[1] !== 1'b0 || rd4(1) !== 32'hABCD) begin bad++;
            $display("FAIL sb_wb_bypass got busy=%b data=%h exp=0,abcd", rbusy4[1], rd4(1)); end
        total++; if (rbusy2[1] !== 1'b1) begin bad++; $display("FAIL sb_wb_nobypass got=%b exp=1", rbusy2[1]); end
        step();
        total++; if (cnt4 !== 6'd0 || rbusy2[1] !== 1'b0 || rd2(1) !== 32'hABCD) begin bad++;
            $display("FAIL sb_cleared got cnt=%0d busy=%b data=%h exp=0,0,abcd", cnt4, rbusy2[1], rd2(1)); end
    endtask

    task automatic test_back_to_back();
        for (int a = 10; a <= 12; a++) begin
            issue_en = 1'b1; issue_addr = 5'(a);
            step();
        end
        total++; if (cnt4 !== 6'd3) begin bad++; $display("FAIL b2b_cnt3 got=%0d exp=3", cnt4); end
        wen0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h10;
        wen1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h11;
        step();
        set_ra(0, 5'd10); set_ra(1, 5'd11); set_ra(2, 5'd12);
        #1;
        total++; if (cnt4 !== 6'd1 || rbusy4[2:0] !== 3'b100) begin bad++;
            $display("FAIL b2b_clear got cnt=%0d rbusy=%b exp=1,100", cnt4, rbusy4[2:0]); end
        flush = 1'b1;
        step();
        total++; if (cnt4 !== 6'd0) begin bad++; $display("FAIL b2b_flush got=%0d exp=0", cnt4); end
    endtask

    task automatic test_simultaneous();
        issue_en = 1'b1; issue_addr = 5'd9;
        wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
        step();
        set_ra(0, 5'd9); set_ra(1, 5'd3);
        #1;
        total++; if (rbusy4[0] !== 1'b1 || cnt4 !== 6'd1 || rd4(0) !== 32'h99) begin bad++;
            $display("FAIL simul_issue_wr got busy=%b cnt=%0d data=%h exp=1,1,99", rbusy4[0], cnt4, rd4(0)); end
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd3;
        step();
        total++; if (cnt4 !== 6'd0 || rbusy4 !== 4'd0 || rbusy2 !== 2'd0) begin bad++;
            $display("FAIL simul_flush got cnt=%0d rbusy=%b/%b exp=0", cnt4, rbusy4, rbusy2); end
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        int          errs;
        for (int a = 0; a < 32; a += 2) begin
            wen0 = 1'b1; waddr0 = 5'(a);     wdata0 = a * 32'h01010101;
            wen1 = 1'b1; waddr1 = 5'(a + 1); wdata1 = (a + 1) * 32'h01010101;
            step();
        end
        for (int k = 0; k < 32; k += 4) begin
            for (int p = 0; p < 4; p++) set_ra(p, 5'(k + p));
            #1;
            errs = 0;
            for (int p = 0; p < 4; p++) begin
                exp = (k + p) * 32'h01010101;
                if (rd4(p) !== exp) errs++;
                if (p < 2 && rd2(p) !== exp) errs++;
            end
            exp = k * 32'h01010101;
            if (rdata1 !== exp) errs++;
            total++; if (errs != 0) begin bad++;
                $display("FAIL sweep_k%0d got=%h,%h,%h,%h p0_1port=%h exp_base=%h", k,
                         rd4(0), rd4(1), rd4(2), rd4(3), rdata1, exp); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle(); raddr = '0; rst_n = 1'b0;
        test_reset();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_back_to_back();
        test_simultaneous();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
